// File: rtl/rr_dec_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter:
//   - requester count and index width
//   - FSM state encoding (IDLE / GRANT / GAP)
//   - rr_pick: rotating-priority search helper
package rr_dec_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Returns the first set request bit, searching ptr, ptr+1, ... modulo N_REQ.
    // The return value is only meaningful when req != 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_dec_arbiter_decoder.sv
// 2-to-4 one-hot decoder with enable.
//   en_i : when 0, output is all zeros
//   a_i  : 2-bit select
//   y_o  : one-hot output, y_o[a_i] = en_i
module rr_dec_arbiter_decoder (
    input  logic       en_i,
    input  logic [1:0] a_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = 4'b0000;
        if (en_i) begin
            y_o[a_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ requesters with a
// bounded grant hold time. All outputs are registered; the one-hot grant is
// decoded from the registered index/valid pair.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   en_i         : enable; when low, no new grant is issued (active grant continues)
//   req_i        : request vector, req_i[i] held high while requester i wants/uses the resource
//   gnt_o        : one-hot grant, all zero while gnt_valid_o is low
//   gnt_idx_o    : index of current / last grantee
//   gnt_valid_o  : high while a grant is active
//   timeout_o    : one-cycle pulse when a grant is forcibly ended at MAX_HOLD
//   state_o      : current FSM state (debug)
//   ptr_o        : current priority pointer (debug)
//
// Handshake: a requester raises req_i[i] and keeps it high; it owns the
// resource in every cycle where gnt_o[i] is high, and releases it by dropping
// req_i[i]. The grant ends on the edge after the drop, or after MAX_HOLD cycles.
module rr_dec_arbiter
    import rr_dec_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o,
    output arb_state_e       state_o,
    output logic [IDX_W-1:0] ptr_o
);

    localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] winner;
    logic             hold_done;
    logic             grantee_req;

    always_comb begin
        winner      = rr_pick(req_i, ptr_q);
        hold_done   = (cnt_q == MAX_CNT);
        grantee_req = req_i[idx_q];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i && (|req_i)) begin
                    idx_d   = winner;
                    valid_d = 1'b1;
                    cnt_d   = HOLD_W'(1);
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // en_i is deliberately ignored here: an active grant is never aborted.
                if (!grantee_req || hold_done) begin
                    valid_d   = 1'b0;
                    // Just-served requester drops to lowest priority next time.
                    ptr_d     = idx_q + IDX_W'(1);
                    state_d   = ST_GAP;
                    timeout_d = hold_done && grantee_req;
                end else begin
                    // hold_done is false here, so the count can never wrap.
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end

            ST_GAP: begin
                // One bus-turnaround cycle; requests are sampled again in IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    rr_dec_arbiter_decoder u_dec (
        .en_i (valid_q),
        .a_i  (idx_q),
        .y_o  (gnt_o)
    );

    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign timeout_o   = timeout_q;
    assign state_o     = state_q;
    assign ptr_o       = ptr_q;

endmodule
